i2c_tx_fsm: RTL
===============

# i2c_tx_fsm

Transmit side of the I2C slave used by the FIR filter control interface: serializes read-data bytes onto SDA during I2C read transfers, one bit per SCL low phase, MSB first, then releases SDA and samples the master's ACK/NACK. It consumes the same synchronized `start_in`/`stop_in`/`scl_rise_in`/`scl_fall_in` strobes as the receive FSM and is enabled by that FSM when a read address has been acknowledged. SDA is open-drain: the block only ever pulls low via `oe_out`.

## Interface
- `UNDERRUN_DATA`, 8'hFF: byte transmitted when no data was handed over before the first bit of a byte must be driven.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `start_in`  in  1  one-cycle strobe, START or repeated START detected.
- `stop_in`  in  1  one-cycle strobe, STOP detected.
- `scl_rise_in`  in  1  one-cycle strobe, SCL rising edge.
- `scl_fall_in`  in  1  one-cycle strobe, SCL falling edge.
- `sda_in`  in  1  synchronized SDA level.
- `tx_en_in`  in  1  level, high while the receive FSM drives the ACK of a read (R/W=1) address byte.
- `tx_data_in`  in  8  byte to transmit.
- `tx_valid_in`  in  1  `tx_data_in` valid.
- `tx_ready_out`  out  1  block accepts a byte this cycle; transfer when `tx_valid_in & tx_ready_out`.
- `oe_out`  out  1  1 = pull SDA low.
- `ack_out`  out  1  one-cycle pulse, master ACKed a byte.
- `nack_out`  out  1  one-cycle pulse, master NACKed a byte.
- `underrun_out`  out  1  one-cycle pulse, `UNDERRUN_DATA` substituted.
- `busy_out`  out  1  high in every state except IDLE.

## Operation
- Registers: `state_r`, `shift_r[7:0]`, `bit_cnt_r[2:0]`, `loaded_r`.
- IDLE: all outputs 0. `tx_en_in`=1 -> ARM with `loaded_r`=0.
- ARM: `tx_ready_out` = ~`loaded_r`. On handshake: `shift_r` <= `tx_data_in`, `loaded_r` <= 1. On `scl_fall_in`: `bit_cnt_r` <= 0, -> SHIFT; if no byte loaded (including handshake in the same cycle: handshake wins, that byte is sent), `shift_r` <= `UNDERRUN_DATA` and `underrun_out` pulses.
- SHIFT: `oe_out` = ~`shift_r[7]`. On `scl_fall_in`: if `bit_cnt_r`=7 -> ACKW; else `shift_r` <= `shift_r` << 1, `bit_cnt_r` += 1.
- ACKW: `oe_out`=0. On `scl_rise_in`: `sda_in`=0 -> `ack_out` pulse, `loaded_r` <= 0, -> ARM; `sda_in`=1 -> `nack_out` pulse, -> DONE.
- DONE: `oe_out`=0, waits for bus event.
- `start_in` or `stop_in` in any non-IDLE state -> IDLE, overriding all other transitions; a loaded but unsent byte is discarded (no handshake to return it).
- `tx_en_in` ignored outside IDLE.

## Timing
- Reset: `state_r`=IDLE, `shift_r`=0, `bit_cnt_r`=0, `loaded_r`=0; all outputs 0 during and after reset.
- `oe_out`, `tx_ready_out`, `busy_out` are combinational from registers only (no input-to-output path); `oe_out` changes 1 clk after the `scl_fall_in` strobe, valid for the whole SCL high phase.
- `ack_out`/`nack_out`/`underrun_out` are registered pulses, asserted the cycle after the triggering strobe.
- Byte = 9 SCL clocks: falls 1..8 launch bits 7..0, fall 9 releases SDA, rise 9 samples ACK.
- Data must be handed over before the falling edge that launches bit 7; no clock stretching.
- Strobes are mutually exclusive by construction; if `stop_in` and `scl_fall_in` coincide, stop wins.

## Structure
- `fir_filter_pkg`: `i2c_tx_state_t` enum {IDLE, ARM, SHIFT, ACKW, DONE}, `I2C_BYTE_BITS` = 8.
- Single module; no sub-module. The top-level I2C slave ORs `oe_out` with the receive FSM's `oe_out`.

## Test plan
- Reset mid-SHIFT (byte 8'h3C, after 3 bits) -> next clk state IDLE, `oe_out`=0, `busy_out`=0.
- `tx_en_in`, handshake 8'hA5, 9 SCL clocks with `sda_in`=0 at rise 9 -> `oe_out` sequence per bit 0,1,0,1,1,0,1,0 (pull-low on 0 bits), released at fall 9, `ack_out` one pulse, state ARM.
- Two bytes 8'h01, 8'h80, ACK then NACK -> correct bit patterns, `ack_out` then `nack_out`, DONE; `stop_in` -> IDLE.
- No handshake before first fall -> `underrun_out` pulse, 8'hFF sent (`oe_out`=0 all 8 bits).
- Handshake coincident with `scl_fall_in` in ARM -> that byte (8'h55) sent, no underrun.
- `start_in` during bit 4 -> IDLE, `oe_out`=0 next clk, subsequent SCL strobes ignored until new `tx_en_in`.

Source files
------------

// File: rtl/fir_filter_pkg.sv
// Shared types for the FIR filter I2C control slave.
package fir_filter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SHIFT,
    ACKW,
    DONE
  } i2c_tx_state_t;

  localparam int I2C_BYTE_BITS = 8;

endpackage

// File: rtl/i2c_tx_fsm.sv
// I2C slave read-data serializer: loads a byte in ARM, drives it MSB first on SCL falls, samples ACK on rise 9.
// oe_out/tx_ready_out/busy_out decode registers only; ack/nack/underrun pulse one clk after their strobe.
module i2c_tx_fsm
  import fir_filter_pkg::*;
#(
  parameter logic [7:0] UNDERRUN_DATA = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_in,
  input  logic       stop_in,
  input  logic       scl_rise_in,
  input  logic       scl_fall_in,
  input  logic       sda_in,
  input  logic       tx_en_in,
  input  logic [7:0] tx_data_in,
  input  logic       tx_valid_in,
  output logic       tx_ready_out,
  output logic       oe_out,
  output logic       ack_out,
  output logic       nack_out,
  output logic       underrun_out,
  output logic       busy_out
);

  localparam logic [2:0] LAST_BIT = 3'(I2C_BYTE_BITS - 1);

  i2c_tx_state_t state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          loaded_q, loaded_d;
  logic          ack_q, ack_d;
  logic          nack_q, nack_d;
  logic          underrun_q, underrun_d;
  logic          handshake;

  assign tx_ready_out = (state_q == ARM) && !loaded_q;
  assign handshake    = tx_valid_in && tx_ready_out;
  assign oe_out       = (state_q == SHIFT) && !shift_q[7];
  assign busy_out     = (state_q != IDLE);
  assign ack_out      = ack_q;
  assign nack_out     = nack_q;
  assign underrun_out = underrun_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    loaded_d   = loaded_q;
    ack_d      = 1'b0;
    nack_d     = 1'b0;
    underrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_en_in) begin
          state_d  = ARM;
          loaded_d = 1'b0;
        end
      end
      ARM: begin
        if (handshake) begin
          shift_d  = tx_data_in;
          loaded_d = 1'b1;
        end
        // A byte handed over on the launching edge itself still makes it out.
        if (scl_fall_in) begin
          bit_cnt_d = '0;
          state_d   = SHIFT;
          if (!(loaded_q || handshake)) begin
            shift_d    = UNDERRUN_DATA;
            underrun_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (scl_fall_in) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ACKW;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ACKW: begin
        if (scl_rise_in) begin
          if (!sda_in) begin
            ack_d    = 1'b1;
            loaded_d = 1'b0;
            state_d  = ARM;
          end else begin
            nack_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus START/STOP aborts the read; any loaded byte is simply dropped.
    if ((state_q != IDLE) && (start_in || stop_in)) begin
      state_d    = IDLE;
      loaded_d   = 1'b0;
      ack_d      = 1'b0;
      nack_d     = 1'b0;
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      loaded_q   <= 1'b0;
      ack_q      <= 1'b0;
      nack_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      loaded_q   <= loaded_d;
      ack_q      <= ack_d;
      nack_q     <= nack_d;
      underrun_q <= underrun_d;
    end
  end

endmodule
